// File: rtl/dense_layer_sequencer.sv
`timescale 1ns/1ps
// Sequencer for a bank of dense accumulator units sharing one feature stream.
// On go it clears the units, walks the feature buffer in (counter1, counter2)
// order, re-times the unit counters to the feature-memory read latency,
// snapshots every unit sum and streams the snapshot out one word per handshake.
module dense_layer_sequencer #(
  parameter int OUTER     = 16,
  parameter int INNER     = 8,
  parameter int NUM_UNITS = 16,
  parameter int RD_LAT    = 1,
  parameter int ADDR_W    = 7,
  localparam int IDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  output logic                    go_ready,
  output logic                    busy,
  output logic                    feat_rd_en,
  output logic [ADDR_W-1:0]       feat_addr,
  output logic [4:0]              counter1,
  output logic [4:0]              counter2,
  output logic                    acc_en,
  output logic                    start,
  input  logic [NUM_UNITS*16-1:0] unit_sums,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15:0]      out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last
);

  localparam logic [4:0]       C1_LAST    = 5'(OUTER - 1);
  localparam logic [4:0]       C2_LAST    = 5'(INNER - 1);
  localparam logic [4:0]       HOLD_CODE  = 5'd8;
  localparam int               DR_W       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(RD_LAT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_UNITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_SNAP,
    S_STREAM
  } state_t;

  state_t r_state;
  state_t w_next;

  // Issue-side walk counters (address generation)
  logic [4:0]        r_c1;
  logic [4:0]        r_c2;
  logic [DR_W-1:0]   r_drain;

  // Latency-matching pipeline: stage RD_LAT-1 drives the unit counters
  logic              r_pv  [RD_LAT];
  logic [4:0]        r_pc1 [RD_LAT];
  logic [4:0]        r_pc2 [RD_LAT];

  // Snapshot of unit sums and stream position
  logic signed [15:0] r_buf [NUM_UNITS];
  logic [IDX_W-1:0]   r_idx;

  logic              w_issue;
  logic              w_issue_last;
  logic              w_idx_last;
  logic              w_hs;
  logic [ADDR_W-1:0] w_addr;

  assign w_issue      = (r_state == S_RUN);
  assign w_issue_last = w_issue && (r_c1 == C1_LAST) && (r_c2 == C2_LAST);
  assign w_idx_last   = (r_idx == IDX_LAST);
  assign w_hs         = (r_state == S_STREAM) && out_ready;
  assign w_addr       = ADDR_W'(r_c1) * ADDR_W'(INNER) + ADDR_W'(r_c2);

  assign feat_addr = w_issue ? w_addr : '0;
  assign acc_en    = r_pv[RD_LAT-1];
  assign counter1  = r_pc1[RD_LAT-1];
  // Outside a data cycle the hold code keeps the units from accumulating
  assign counter2  = acc_en ? r_pc2[RD_LAT-1] : HOLD_CODE;
  assign out_data  = out_valid ? r_buf[r_idx] : '0;
  assign out_idx   = r_idx;
  assign out_last  = out_valid && w_idx_last;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-state control outputs
  always_comb begin
    w_next     = r_state;
    go_ready   = 1'b0;
    busy       = 1'b1;
    start      = 1'b0;
    feat_rd_en = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        go_ready = 1'b1;
        busy     = 1'b0;
        if (go) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        start  = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        feat_rd_en = 1'b1;
        if (w_issue_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) w_next = S_SNAP;
      end
      S_SNAP: begin
        w_next = S_STREAM;
      end
      S_STREAM: begin
        out_valid = 1'b1;
        if (out_ready && w_idx_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Walk c2 fastest, bumping c1 on each c2 wrap; both wrap to 0 after the last word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c1 <= '0;
      r_c2 <= '0;
    end else if (w_issue) begin
      if (r_c2 == C2_LAST) begin
        r_c2 <= '0;
        r_c1 <= (r_c1 == C1_LAST) ? '0 : r_c1 + 5'd1;
      end else begin
        r_c2 <= r_c2 + 5'd1;
      end
    end
  end

  // Count the drain cycles that let the last read word reach the units
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drain <= '0;
    end else if ((r_state == S_DRAIN) && (r_drain != DRAIN_LAST)) begin
      r_drain <= r_drain + DR_W'(1);
    end else begin
      r_drain <= '0;
    end
  end

  // Delay issue valid/counters by RD_LAT; counters only move with a valid word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < RD_LAT; s++) begin
        r_pv[s]  <= 1'b0;
        r_pc1[s] <= '0;
        r_pc2[s] <= '0;
      end
    end else begin
      r_pv[0] <= w_issue;
      if (w_issue) begin
        r_pc1[0] <= r_c1;
        r_pc2[0] <= r_c2;
      end
      for (int s = 1; s < RD_LAT; s++) begin
        r_pv[s] <= r_pv[s-1];
        if (r_pv[s-1]) begin
          r_pc1[s] <= r_pc1[s-1];
          r_pc2[s] <= r_pc2[s-1];
        end
      end
    end
  end

  // Capture all unit sums once the final accumulate has settled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) r_buf[i] <= '0;
    end else if (r_state == S_SNAP) begin
      for (int i = 0; i < NUM_UNITS; i++) r_buf[i] <= unit_sums[16*i +: 16];
    end
  end

  // Advance the stream index on each accepted word, rewinding after the last
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_hs) begin
      r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
    end
  end

endmodule
